maze_collision_checker: RTL and testbench

- Responder side of the sprite-movement collision query; ghost and Pac-Man movers are the initiators.
- Mover presents its top-left position and intended direction. Block computes the two leading-edge probe pixels of a one-pixel step and looks both up in the maze wall-tile ROM.
- Answers whether the step is clear. One query in flight at a time; valid/ready on both request and response.

---
 rtl/maze_collision_checker.sv | 163 ++++++++++++++++
 tb/tb_maze_collision_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_collision_checker.sv
// Collision query responder: probes the two leading-edge pixels of a one-pixel sprite step
// against the wall-tile ROM. Define WRAP_TUNNEL_EN to wrap horizontal moves through the side tunnel.
module maze_collision_checker #(
    parameter int SPRITE     = 16,
    parameter int TILE_SHIFT = 3,
    parameter int MAP_W      = 80,
    parameter int MAP_H      = 60,
    parameter int FIELD_W    = 640,
    parameter int FIELD_H    = 480,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    input  logic [1:0]        dir,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_clear,
    output logic              map_rd_en,
    output logic [ADDR_W-1:0] map_addr,
    input  logic              map_data
);

    typedef enum logic [2:0] {IDLE, CALC, RD_A, RD_B, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [9:0]        x_p0;
    logic [8:0]        y_p0;
    logic [1:0]        dir_p0;
    logic [ADDR_W-1:0] addr_a_p1, addr_b_p1;
    logic              oob_p1;
    logic              wall_a_p2;

    logic [10:0] x11, y11;
    logic [11:0] x_dec, y_dec;
    logic [10:0] xa, xb, ya, yb;
    logic        neg_x, neg_y, oob;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [10:0] px, input logic [10:0] py);
        logic [10:0] tx, ty;
        tx = px >> TILE_SHIFT;
        ty = py >> TILE_SHIFT;
        return ADDR_W'(ty) * ADDR_W'(MAP_W) + ADDR_W'(tx);
    endfunction

    function automatic logic off_field(input logic [10:0] p, input int limit, input int tiles);
        return (p >= 11'(limit)) || ((p >> TILE_SHIFT) >= 11'(tiles));
    endfunction

    // CALC: probe coordinates in 11 bits; bit 11 of the decrements is the borrow
    always_comb begin
        x11   = {1'b0, x_p0};
        y11   = {2'b00, y_p0};
        x_dec = {1'b0, x11} - 12'd1;
        y_dec = {1'b0, y11} - 12'd1;
        xa    = x11;
        xb    = x11 + 11'(SPRITE - 1);
        ya    = y11;
        yb    = y11 + 11'(SPRITE - 1);
        neg_x = 1'b0;
        neg_y = 1'b0;
        case (dir_p0)
            2'b00: begin
                ya    = y_dec[10:0];
                yb    = y_dec[10:0];
                neg_y = y_dec[11];
            end
            2'b01: begin
                ya = y11 + 11'(SPRITE);
                yb = y11 + 11'(SPRITE);
            end
            2'b10: begin
                xa    = x_dec[10:0];
                xb    = x_dec[10:0];
                neg_x = x_dec[11];
            end
            default: begin
                xa = x11 + 11'(SPRITE);
                xb = x11 + 11'(SPRITE);
            end
        endcase
`ifdef WRAP_TUNNEL_EN
        // Left/right moves share one probe column, so both probes wrap together
        if (dir_p0[1]) begin
            if (neg_x) begin
                xa    = 11'(FIELD_W - 1);
                xb    = 11'(FIELD_W - 1);
                neg_x = 1'b0;
            end else if (xa >= 11'(FIELD_W)) begin
                xa = xa - 11'(FIELD_W);
                xb = xa;
            end
        end
`endif
        oob = neg_x || neg_y
            || off_field(xa, FIELD_W, MAP_W) || off_field(xb, FIELD_W, MAP_W)
            || off_field(ya, FIELD_H, MAP_H) || off_field(yb, FIELD_H, MAP_H);
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        map_rd_en  = 1'b0;
        map_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = CALC;
            end
            // Blocked answers still pass through WAIT so they surface two cycles after acceptance
            CALC: state_next = oob ? WAIT : RD_A;
            RD_A: begin
                map_rd_en  = 1'b1;
                map_addr   = addr_a_p1;
                state_next = RD_B;
            end
            RD_B: begin
                map_rd_en  = 1'b1;
                map_addr   = addr_b_p1;
                state_next = WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            resp_clear <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT) resp_clear <= ~(wall_a_p2 | map_data) & ~oob_p1;
        end
    end

    always_ff @(posedge clk) begin
        // p0: request capture
        if (state == IDLE && req_valid) begin
            x_p0   <= pos_x;
            y_p0   <= pos_y;
            dir_p0 <= dir;
        end
        // p1: tile addresses and bounds verdict
        if (state == CALC) begin
            addr_a_p1 <= tile_addr(xa, ya);
            addr_b_p1 <= tile_addr(xb, yb);
            oob_p1    <= oob;
        end
        // p2: first wall bit returns while probe B is being read
        if (state == RD_B) wall_a_p2 <= map_data;
    end

endmodule

// File: tb/tb_maze_collision_checker.sv
// Scoreboard bench for maze_collision_checker with a one-cycle-latency wall ROM model.
module tb_maze_collision_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  pos_x = '0;
    logic [8:0]  pos_y = '0;
    logic [1:0]  dir = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_clear;
    logic        map_rd_en;
    logic [12:0] map_addr;
    logic        map_data = 1'b0;

    bit wall_map [0:8191];

    typedef struct {bit clear; int lat; int nreads; int ra; int rb;} exp_t;
    typedef struct {bit acc; int lat; bit clear; int nreads; int ra; int rb; bit stable; bit idle;} obs_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    maze_collision_checker dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_clear(resp_clear), .map_rd_en(map_rd_en),
        .map_addr(map_addr), .map_data(map_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (map_rd_en) map_data <= wall_map[map_addr];

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_map();
        for (int i = 0; i < 8192; i++) wall_map[i] = 1'b0;
    endtask

    function automatic exp_t model(int x, int y, int d);
        exp_t e;
        int xa, xb, ya, yb, a, b;
        xa = x; xb = x + 15; ya = y; yb = y + 15;
        case (d)
            0: begin ya = y - 1; yb = y - 1; end
            1: begin ya = y + 16; yb = y + 16; end
            2: begin xa = x - 1; xb = x - 1; end
            default: begin xa = x + 16; xb = x + 16; end
        endcase
`ifdef WRAP_TUNNEL_EN
        if (d >= 2) begin
            if (xa < 0) xa += 640;
            else if (xa >= 640) xa -= 640;
            xb = xa;
        end
`endif
        if (xa < 0 || xb < 0 || ya < 0 || yb < 0 || xa >= 640 || xb >= 640 || ya >= 480 || yb >= 480) begin
            e = '{1'b0, 2, 0, -1, -1};
        end else begin
            a = (ya / 8) * 80 + xa / 8;
            b = (yb / 8) * 80 + xb / 8;
            e = '{!(wall_map[a] || wall_map[b]), 4, 2, a, b};
        end
        return e;
    endfunction

    task automatic do_query(input int x, input int y, input int d, input int hold, output obs_t o);
        o = '{1'b0, -1, 1'b0, 0, -1, -1, 1'b1, 1'b0};
        o.acc = req_ready;
        pos_x = 10'(x); pos_y = 9'(y); dir = 2'(d); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        pos_x = 10'($urandom); pos_y = 9'($urandom); dir = 2'($urandom);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (map_rd_en) begin
                if (o.nreads == 0) o.ra = int'(map_addr);
                else if (o.nreads == 1) o.rb = int'(map_addr);
                o.nreads++;
            end
            if (resp_valid) begin
                o.lat = k;
                o.clear = resp_clear;
                break;
            end
        end
        if (o.lat >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_clear !== o.clear || req_ready !== 1'b0) o.stable = 1'b0;
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            o.idle = req_ready && !resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; pos_x = 10'd200; pos_y = 9'd146; dir = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 4;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready cyc %0d got %b want 1", i, req_ready); end
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid cyc %0d got %b want 0", i, resp_valid); end
            if (map_rd_en !== 1'b0) begin errors++; $display("FAIL reset_map_rd_en cyc %0d got %b want 0", i, map_rd_en); end
            if (map_addr !== 13'd0) begin errors++; $display("FAIL reset_map_addr cyc %0d got %0d want 0", i, map_addr); end
        end
        rst = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || map_rd_en !== 1'b0 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_no_accept cyc %0d got ready=%b rd=%b vld=%b want 1 0 0", i, req_ready, map_rd_en, resp_valid);
            end
        end
    endtask

    task automatic test_open_path();
        int qx[2] = '{200, 200};
        int qy[2] = '{146, 146};
        int qd[2] = '{0, 1};
        exp_t e; obs_t o;
        clear_map();
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model(qx[i], qy[i], qd[i]));
            do_query(qx[i], qy[i], qd[i], 0, o);
            e = sb.pop_front();
            checks += 7;
            if (o.acc !== 1'b1) begin errors++; $display("FAIL open_accept[%0d] got %b want 1", i, o.acc); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL open_latency[%0d] got %0d want %0d", i, o.lat, e.lat); end
            if (o.clear !== e.clear) begin errors++; $display("FAIL open_clear[%0d] got %b want %b", i, o.clear, e.clear); end
            if (o.nreads !== e.nreads) begin errors++; $display("FAIL open_nreads[%0d] got %0d want %0d", i, o.nreads, e.nreads); end
            if (o.ra !== e.ra) begin errors++; $display("FAIL open_addr_a[%0d] got %0d want %0d", i, o.ra, e.ra); end
            if (o.rb !== e.rb) begin errors++; $display("FAIL open_addr_b[%0d] got %0d want %0d", i, o.rb, e.rb); end
            if (o.idle !== 1'b1) begin errors++; $display("FAIL open_idle[%0d] got %b want 1", i, o.idle); end
        end
    endtask

    task automatic test_wall_hit();
        int wbit[3] = '{1466, 1465, 1467};
        exp_t e; obs_t o;
        for (int i = 0; i < 3; i++) begin
            clear_map();
            wall_map[wbit[i]] = 1'b1;
            sb.push_back(model(200, 146, 0));
            do_query(200, 146, 0, 0, o);
            e = sb.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL wall_latency[%0d] got %0d want %0d", i, o.lat, e.lat); end
            if (o.clear !== e.clear) begin errors++; $display("FAIL wall_clear[%0d] got %b want %b", i, o.clear, e.clear); end
            if (o.ra !== e.ra || o.rb !== e.rb) begin errors++; $display("FAIL wall_addrs[%0d] got %0d,%0d want %0d,%0d", i, o.ra, o.rb, e.ra, e.rb); end
            if (o.idle !== 1'b1) begin errors++; $display("FAIL wall_idle[%0d] got %b want 1", i, o.idle); end
        end
    endtask

    task automatic test_oob();
        int qx[5] = '{0, 624, 100, 100, 625};
        int qy[5] = '{100, 50, 0, 464, 100};
        int qd[5] = '{2, 3, 0, 1, 0};
        exp_t e; obs_t o;
        clear_map();
        wall_map[1039] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model(qx[i], qy[i], qd[i]));
            do_query(qx[i], qy[i], qd[i], 0, o);
            e = sb.pop_front();
            checks += 6;
            if (o.lat !== e.lat) begin errors++; $display("FAIL oob_latency[%0d] got %0d want %0d", i, o.lat, e.lat); end
            if (o.clear !== e.clear) begin errors++; $display("FAIL oob_clear[%0d] got %b want %b", i, o.clear, e.clear); end
            if (o.nreads !== e.nreads) begin errors++; $display("FAIL oob_nreads[%0d] got %0d want %0d", i, o.nreads, e.nreads); end
            if (o.ra !== e.ra) begin errors++; $display("FAIL oob_addr_a[%0d] got %0d want %0d", i, o.ra, e.ra); end
            if (o.rb !== e.rb) begin errors++; $display("FAIL oob_addr_b[%0d] got %0d want %0d", i, o.rb, e.rb); end
            if (o.idle !== 1'b1) begin errors++; $display("FAIL oob_idle[%0d] got %b want 1", i, o.idle); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        clear_map();
        wall_map[1625] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model(200, 146, 1 - i));
            do_query(200, 146, 1 - i, (i == 0) ? 10 : 0, o);
            e = sb.pop_front();
            checks += 5;
            if (o.acc !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got %b want 1", i, o.acc); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, o.lat, e.lat); end
            if (o.clear !== e.clear) begin errors++; $display("FAIL b2b_clear[%0d] got %b want %b", i, o.clear, e.clear); end
            if (o.stable !== 1'b1) begin errors++; $display("FAIL b2b_hold_stable[%0d] got %b want 1", i, o.stable); end
            if (o.idle !== 1'b1) begin errors++; $display("FAIL b2b_idle[%0d] got %b want 1", i, o.idle); end
        end
    endtask

    task automatic test_midop_reset();
        exp_t e; obs_t o;
        bit seen_valid;
        clear_map();
        wall_map[1465] = 1'b1;
        wall_map[1466] = 1'b1;
        pos_x = 10'd200; pos_y = 9'd146; dir = 2'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (map_rd_en !== 1'b1 || map_addr !== 13'd1466) begin
            errors++; $display("FAIL midrst_in_rd_b got rd=%b addr=%0d want 1 1466", map_rd_en, map_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || map_rd_en !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got ready=%b vld=%b rd=%b want 1 0 0", req_ready, resp_valid, map_rd_en);
        end
        seen_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin errors++; $display("FAIL midrst_no_resp got resp_valid=1 want 0"); end
        clear_map();
        sb.push_back(model(200, 146, 0));
        do_query(200, 146, 0, 0, o);
        e = sb.pop_front();
        checks += 3;
        if (o.lat !== e.lat) begin errors++; $display("FAIL midrst_fresh_latency got %0d want %0d", o.lat, e.lat); end
        if (o.clear !== e.clear) begin errors++; $display("FAIL midrst_fresh_clear got %b want %b", o.clear, e.clear); end
        if (o.ra !== e.ra || o.rb !== e.rb) begin errors++; $display("FAIL midrst_fresh_addrs got %0d,%0d want %0d,%0d", o.ra, o.rb, e.ra, e.rb); end
    endtask

    task automatic test_random();
        exp_t e; obs_t o;
        int x, y, d;
        for (int i = 0; i < 8192; i++) wall_map[i] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 16; i++) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            d = $urandom_range(0, 3);
            sb.push_back(model(x, y, d));
            do_query(x, y, d, $urandom_range(0, 3), o);
            e = sb.pop_front();
            checks += 5;
            if (o.lat !== e.lat) begin errors++; $display("FAIL rand_latency[%0d] x=%0d y=%0d d=%0d got %0d want %0d", i, x, y, d, o.lat, e.lat); end
            if (o.clear !== e.clear) begin errors++; $display("FAIL rand_clear[%0d] x=%0d y=%0d d=%0d got %b want %b", i, x, y, d, o.clear, e.clear); end
            if (o.ra !== e.ra || o.rb !== e.rb) begin errors++; $display("FAIL rand_addrs[%0d] got %0d,%0d want %0d,%0d", i, o.ra, o.rb, e.ra, e.rb); end
            if (o.stable !== 1'b1) begin errors++; $display("FAIL rand_stable[%0d] got %b want 1", i, o.stable); end
            if (o.idle !== 1'b1) begin errors++; $display("FAIL rand_idle[%0d] got %b want 1", i, o.idle); end
        end
    endtask

    initial begin
        clear_map();
        test_reset();
        test_open_path();
        test_wall_hit();
        test_oob();
        test_back_to_back();
        test_midop_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
